// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master round-robin data RAM arbiter with bounded lock
module dram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic             last;
  logic             owner_lock;
  logic [CNT_W-1:0] lock_cnt;
  logic             both;
  logic             pick1;
  logic             gnt0;
  logic             gnt1;
  logic             any_gnt;
  logic             g_lock;
  logic             g_we;

  // Lock is honoured only while contested and below the bound; otherwise round-robin.
  always_comb begin
    both = m0_req & m1_req;
    if (both && owner_lock && (lock_cnt < CNT_MAX)) pick1 = last;
    else if (both)                                  pick1 = ~last;
    else                                            pick1 = m1_req;
    gnt0 = ~rst & m0_req & ~pick1;
    gnt1 = ~rst & m1_req & pick1;
  end

  assign any_gnt   = gnt0 | gnt1;
  assign g_lock    = gnt1 ? m1_lock : m0_lock;
  assign g_we      = gnt1 ? m1_we : m0_we;
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign ram_we    = any_gnt & g_we;
  assign ram_waddr = gnt1 ? m1_addr : m0_addr;
  assign ram_raddr = gnt1 ? m1_addr : m0_addr;
  assign ram_wdata = gnt1 ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 1'b1;
      owner_lock <= 1'b0;
      lock_cnt   <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      rd_data    <= '0;
    end else begin
      m0_rvalid <= gnt0 & ~m0_we;
      m1_rvalid <= gnt1 & ~m1_we;
      if (any_gnt) begin
        last       <= gnt1;
        owner_lock <= g_lock;
        // "Other master requested" is exactly the contested case here.
        if ((gnt1 == last) && g_lock && both)
          lock_cnt <= (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
        else
          lock_cnt <= '0;
        if (!g_we) rd_data <= ram_rdata;
      end else begin
        owner_lock <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter with reference model
module tb_dram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rd_data(rd_data), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // dataram stand-in: edge write, combinational read
  logic [DW-1:0] ram [0:255];
  assign ram_rdata = ram[ram_raddr[7:0]];
  always @(posedge clk) if (ram_we) ram[ram_waddr[7:0]] <= ram_wdata;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owned the RAM last, whether that owner asked to keep it,
  // and how many contested grants it has kept in a row on the strength of that lock.
  int            m_last;
  bit            m_lock;
  int            m_streak;
  logic [DW-1:0] m_mem [0:255];
  bit            e_rv0, e_rv1;
  logic [DW-1:0] e_rd;

  function automatic int model_pick();
    if (!m0_req && !m1_req) return -1;
    if (m0_req && !m1_req) return 0;
    if (!m0_req && m1_req) return 1;
    if (m_lock && m_streak < LM) return m_last;
    return 1 - m_last;
  endfunction

  function automatic logic [4:0] exp_vec(input int g);
    logic we;
    we = (g == 1) ? m1_we : (g == 0) ? m0_we : 1'b0;
    return {g == 1, g == 0, we, e_rv1, e_rv0};
  endfunction

  task automatic model_reset();
    m_last = 1; m_lock = 0; m_streak = 0; e_rv0 = 0; e_rv1 = 0; e_rd = '0;
  endtask

  task automatic model_commit(input int g);
    bit contested, lk, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    contested = m0_req && m1_req;
    e_rv0 = 0; e_rv1 = 0;
    if (g < 0) begin
      m_lock = 0; m_streak = 0;
      return;
    end
    lk = (g == 1) ? m1_lock : m0_lock;
    we = (g == 1) ? m1_we : m0_we;
    a  = (g == 1) ? m1_addr : m0_addr;
    d  = (g == 1) ? m1_wdata : m0_wdata;
    if (contested && g == m_last && lk) m_streak = (m_streak < LM) ? m_streak + 1 : LM;
    else m_streak = 0;
    m_lock = lk;
    m_last = g;
    if (we) m_mem[a[7:0]] = d;
    else begin
      e_rd = m_mem[a[7:0]];
      if (g == 1) e_rv1 = 1; else e_rv0 = 1;
    end
  endtask

  task automatic set_m0(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = data;
  endtask

  task automatic set_m1(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = data;
  endtask

  task automatic test_reset();
    int g;
    logic [4:0] ev;
    set_m0(1, 0, 0, 32'h0, '0);
    set_m1(1, 0, 0, 32'h4, '0);
    #1;
    model_reset();
    vectors++;
    if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== 5'b0) begin
      miscompares++; $display("FAIL reset ctl: got %b want 00000", {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid});
    end
    vectors++;
    if (rd_data !== '0) begin miscompares++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) set_m0(0, 0, 0, '0, '0);
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL reset_release ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      if (i == 0) begin
        vectors++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin miscompares++; $display("FAIL reset_first_tie: got %b want 01", {m1_gnt, m0_gnt}); end
      end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_single_master();
    int g;
    logic [4:0] ev;
    for (int i = 0; i < 3; i++) begin
      set_m1(0, 0, 0, '0, '0);
      case (i)
        0:       set_m0(1, 1, 0, 32'h10, 32'hDEADBEEF);
        1:       set_m0(1, 0, 0, 32'h10, '0);
        default: set_m0(0, 0, 0, '0, '0);
      endcase
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL single ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if (rd_data !== e_rd) begin miscompares++; $display("FAIL single rd_data cyc%0d: got %h want %h", i, rd_data, e_rd); end
      if (i == 0) begin
        vectors++;
        if (ram_we !== 1'b1 || ram_waddr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin
          miscompares++; $display("FAIL single write: got we=%b a=%h d=%h want 1 10 deadbeef", ram_we, ram_waddr, ram_wdata);
        end
      end
      if (i == 2) begin
        vectors++;
        if (m0_rvalid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
          miscompares++; $display("FAIL single readback: got rv=%b d=%h want 1 deadbeef", m0_rvalid, rd_data);
        end
      end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    int g;
    logic [4:0] ev;
    logic [1:0] want [0:7];
    want = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      begin set_m0(0, 0, 0, '0, '0);     set_m1(1, 0, 0, 32'h8, '0);  end
      else if (i < 7)  begin set_m0(1, 0, 0, 32'h10, '0); set_m1(1, 0, 0, 32'h0, '0);  end
      else             begin set_m0(0, 0, 0, '0, '0);     set_m1(0, 0, 0, '0, '0);     end
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL contention ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if ({m1_gnt, m0_gnt} !== want[i]) begin
        miscompares++; $display("FAIL contention order cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt}, want[i]);
      end
      vectors++;
      if (rd_data !== e_rd) begin miscompares++; $display("FAIL contention rd_data cyc%0d: got %h want %h", i, rd_data, e_rd); end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_lock_bound();
    int g;
    logic [4:0] ev;
    logic [1:0] want [0:10];
    want = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      set_m0(1, 0, 0, 32'h10, '0);
      else if (i < 7)  set_m0(1, 0, 0, 32'h20, '0);
      else if (i < 10) set_m0(1, 0, 0, 32'h10, '0);
      else             set_m0(0, 0, 0, '0, '0);
      if (i >= 1 && i <= 8) set_m1(1, 1, 1, 32'h30 + AW'(i), $urandom);
      else                  set_m1(0, 0, 0, '0, '0);
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL lock_bound ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if ({m1_gnt, m0_gnt} !== want[i]) begin
        miscompares++; $display("FAIL lock_bound order cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt}, want[i]);
      end
      vectors++;
      if (rd_data !== e_rd) begin miscompares++; $display("FAIL lock_bound rd_data cyc%0d: got %h want %h", i, rd_data, e_rd); end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_lock_no_contention();
    int g;
    logic [4:0] ev;
    logic [1:0] want;
    for (int i = 0; i < 12; i++) begin
      if (i < 10)       begin set_m0(0, 0, 0, '0, '0);     set_m1(1, 0, 1, AW'(i), '0); want = 2'b10; end
      else if (i == 10) begin set_m0(1, 0, 0, 32'h31, '0); set_m1(0, 0, 0, '0, '0);    want = 2'b01; end
      else              begin set_m0(0, 0, 0, '0, '0);     set_m1(0, 0, 0, '0, '0);    want = 2'b00; end
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL lock_alone ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if ({m1_gnt, m0_gnt} !== want) begin
        miscompares++; $display("FAIL lock_alone order cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt}, want);
      end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_same_addr_race();
    int g;
    logic [4:0] ev;
    logic [1:0] want [0:3];
    want = '{2'b10, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin set_m0(0, 0, 0, '0, '0);         set_m1(1, 0, 0, 32'h40, '0); end
        1:       begin set_m0(1, 1, 0, 32'h20, 32'h5); set_m1(1, 0, 0, 32'h20, '0); end
        2:       begin set_m0(0, 0, 0, '0, '0);         set_m1(1, 0, 0, 32'h20, '0); end
        default: begin set_m0(0, 0, 0, '0, '0);         set_m1(0, 0, 0, '0, '0);     end
      endcase
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL race ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if ({m1_gnt, m0_gnt} !== want[i]) begin
        miscompares++; $display("FAIL race order cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt}, want[i]);
      end
      if (i == 3) begin
        vectors++;
        if (m1_rvalid !== 1'b1 || rd_data !== 32'h5) begin
          miscompares++; $display("FAIL race readback: got rv=%b d=%h want 1 5", m1_rvalid, rd_data);
        end
      end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    int g;
    logic [4:0] ev;
    set_m1(0, 0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      set_m0(1, 0, 0, (i == 0) ? 32'h10 : 32'h20, '0);
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL midreset pre ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      model_commit(g);
      if (i == 0) @(negedge clk);
    end
    vectors++;
    if (m0_rvalid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL midreset pre rd: got rv=%b d=%h want 1 deadbeef", m0_rvalid, rd_data);
    end
    #1 rst = 1;
    #1;
    model_reset();
    vectors++;
    if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== 5'b0) begin
      miscompares++; $display("FAIL midreset ctl: got %b want 00000", {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid});
    end
    vectors++;
    if (rd_data !== '0) begin miscompares++; $display("FAIL midreset rd_data: got %h want 0", rd_data); end
    @(negedge clk);
    rst = 0;
    set_m0(1, 0, 0, 32'h10, '0);
    set_m1(1, 0, 0, 32'h20, '0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_m0(0, 0, 0, '0, '0);
      if (i == 2) set_m1(0, 0, 0, '0, '0);
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL midreset post ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if (rd_data !== e_rd) begin miscompares++; $display("FAIL midreset post rd_data cyc%0d: got %h want %h", i, rd_data, e_rd); end
      if (i == 0) begin
        vectors++;
        if ({m1_gnt, m0_gnt} !== 2'b01) begin miscompares++; $display("FAIL midreset first_tie: got %b want 01", {m1_gnt, m0_gnt}); end
      end
      model_commit(g);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int g;
    logic [4:0] ev;
    bit pr [0:1], pw [0:1], pl [0:1];
    logic [AW-1:0] pa [0:1];
    logic [DW-1:0] pd [0:1];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int m = 0; m < 2; m++) begin pr[m] = 0; pw[m] = 0; pl[m] = 0; pa[m] = '0; pd[m] = '0; end
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pr[m] && $urandom_range(0, 9) < 6) begin
          pr[m] = 1;
          pw[m] = 1'($urandom_range(0, 1));
          pl[m] = 1'($urandom_range(0, 1));
          pa[m] = AW'($urandom_range(0, 15));
          pd[m] = $urandom;
        end
      end
      set_m0(pr[0], pw[0], pl[0], pa[0], pd[0]);
      set_m1(pr[1], pw[1], pl[1], pa[1], pd[1]);
      #1; g = model_pick(); ev = exp_vec(g);
      vectors++;
      if ({m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid} !== ev) begin
        miscompares++; $display("FAIL random ctl cyc%0d: got %b want %b", i, {m1_gnt, m0_gnt, ram_we, m1_rvalid, m0_rvalid}, ev);
      end
      vectors++;
      if (rd_data !== e_rd) begin miscompares++; $display("FAIL random rd_data cyc%0d: got %h want %h", i, rd_data, e_rd); end
      if (g >= 0) begin
        ea = pa[g]; ed = pd[g];
        vectors++;
        if (ram_waddr !== ea || ram_raddr !== ea || ram_wdata !== ed) begin
          miscompares++; $display("FAIL random mux cyc%0d: got wa=%h ra=%h wd=%h want %h %h %h", i, ram_waddr, ram_raddr, ram_wdata, ea, ea, ed);
        end
      end
      model_commit(g);
      if (g >= 0) pr[g] = 0;
      @(negedge clk);
    end
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    #1;
    vectors++;
    if ({m1_rvalid, m0_rvalid} !== {e_rv1, e_rv0} || rd_data !== e_rd) begin
      miscompares++; $display("FAIL random tail: got rv=%b d=%h want %b %h", {m1_rvalid, m0_rvalid}, rd_data, {e_rv1, e_rv0}, e_rd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    for (int i = 0; i < 256; i++) begin ram[i] = '0; m_mem[i] = '0; end
    model_reset();
    test_reset();
    test_single_master();
    test_contention();
    test_lock_bound();
    test_lock_no_contention();
    test_same_addr_race();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Arbitrates the single data RAM (`dataram`) between two requesters.
- Master 0 is the CPU load/store port. Master 1 is a secondary port: boot loader, or the LED/debug scanner feeding the display controller.
- Sits between the masters and `dataram` in the SoC top.
- Performs one RAM access per cycle:
  - round-robin fairness between masters;
  - optional bounded lock for read-modify-write sequences;
  - registered read-data return.

Parameters:
- ADDR_W, 32, address width (matches RegBus).
- DATA_W, 32, data width (matches RegBus).
- LOCK_MAX, 4, max consecutive contested grants a locking master may hold (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write enable (0 = read).
- m0_lock  in  1  master 0 requests to keep ownership on the next contested cycle.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access executes this cycle.
- m0_rvalid  out  1  read data for master 0 valid on rd_data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as master 0, for master 1.
- rd_data  out  DATA_W  registered read data, shared by both masters; qualified by mX_rvalid.
- ram_we  out  1  to dataram `we`.
- ram_waddr  out  ADDR_W  to dataram `waddr`.
- ram_wdata  out  DATA_W  to dataram `wdata`.
- ram_raddr  out  ADDR_W  to dataram `raddr`.
- ram_rdata  in  DATA_W  from dataram `rdata`; combinational read.

Behaviour:
- RAM contract: dataram writes on the clk rising edge when ram_we=1. Reads are combinational from ram_raddr.
- Registered state:
  - last (1 bit): master granted most recently; reset value 1, so master 0 wins the first tie.
  - owner_lock (1 bit): owner held lock at its last grant.
  - lock_cnt (clog2(LOCK_MAX+1) bits).
  - rvalid regs, rd_data reg.
- Grant (combinational from req inputs and registered state; forced 0 while rst=1):
  - No req: no grant. ram_we=0, address/data outputs hold master 0 values (don't-care).
  - Only mX_req: grant X.
  - Both req, owner_lock=1, lock_cnt<LOCK_MAX: grant last (lock honoured).
  - Both req, otherwise: grant the master that is not last (round-robin).
- Mux: granted master's addr drives both ram_waddr and ram_raddr. Its wdata drives ram_wdata. ram_we = gnt & mX_we.
- Handshake:
  - A master holds req, we, addr, wdata stable until it samples gnt=1.
  - Access completes in the gnt cycle.
  - The master may drop req or issue a new request the next cycle; back-to-back grants are allowed.
- State update on clk edge when a grant occurs (granted master G):
  - last<=G.
  - owner_lock<=mG_lock.
  - lock_cnt: incremented if G==last, mG_lock=1 and the other master requested; otherwise cleared to 0. It saturates at LOCK_MAX.
- No grant: last unchanged; owner_lock<=0; lock_cnt<=0.
- Lock timeout: once lock_cnt==LOCK_MAX, the next contested cycle goes to the other master regardless of lock. Counter then clears.
- Read return:
  - Grant with we=0: rd_data<=ram_rdata; mG_rvalid<=1 next cycle for exactly one cycle.
  - Writes never assert rvalid.
  - rd_data holds its value when no read occurs.
  - Read latency is 1 cycle after gnt.
- Simultaneous read/write to the same address by both masters: serialised by arbitration. The second access sees the first's write, since writes commit at the edge.
- Reset (asynchronous, any time including mid-lock):
  - All gnt, rvalid, ram_we = 0 immediately.
  - rd_data=0, last=1, owner_lock=0, lock_cnt=0.
  - In-flight read return is discarded.
- Only one gnt high per cycle. The arbiter never issues ram_we=1 without a gnt.

Test Plan:
- Reset: assert rst mid-stream with m0 read granted -> gnt/rvalid/ram_we drop combinationally to 0, rd_data=0. After release, both req -> m0 granted first.
- Single master: m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> write cycle gnt with ram_we=1. Read gnt next cycle; m0_rvalid=1, rd_data=0xDEADBEEF one cycle after the read grant.
- Contention: both masters hold read requests continuously for 6 cycles, no lock -> grants alternate m0,m1,m0,m1,m0,m1. Each rvalid follows its grant by one cycle.
- Lock bound, LOCK_MAX=4: m1 holds lock and req while m0 requests -> m1 granted 1 initial + 4 locked cycles. Next cycle m0 granted, lock_cnt cleared.
- Lock without contention: m1 alone with lock for 10 cycles -> 10 consecutive grants, lock_cnt stays 0. m0 then requests -> m0 granted on its first cycle.
- Same-address race: m0 writes 0x5 to addr 0x20 while m1 reads 0x20 in the same cycle (last=1) -> m0 granted first. m1 granted next cycle; its read returns 0x5.
